// File: rtl/seq_det_pkg.sv
// Shared helpers for seq_detector_n: width math, KMP failure table, parameter checks.
// Everything here is evaluated at elaboration time only.
package seq_det_pkg;

    localparam int MAX_W     = 4;
    localparam int MAX_DEPTH = 8;
    localparam int MAX_PBITS = MAX_W * MAX_DEPTH;
    localparam int FAIL_W    = 4;

    typedef logic [MAX_PBITS-1:0]              pat_vec_t;
    typedef logic [(MAX_DEPTH+1)*FAIL_W-1:0]   fail_vec_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] sym_at(input pat_vec_t p, input int w, input int k);
        pat_vec_t mask;
        mask = (pat_vec_t'(1) << w) - pat_vec_t'(1);
        return MAX_W'((p >> (k * w)) & mask);
    endfunction

    // FAIL[k] = longest proper prefix of P[0..k-1] that is also its suffix; entry k at k*FAIL_W.
    function automatic fail_vec_t prefix_fail(input pat_vec_t p, input int w, input int depth);
        fail_vec_t f;
        logic      ok;
        f = '0;
        for (int k = 2; k <= MAX_DEPTH; k++) begin
            if (k <= depth) begin
                for (int len = 1; len < k; len++) begin
                    ok = 1'b1;
                    for (int j = 0; j < len; j++) begin
                        if (sym_at(p, w, j) != sym_at(p, w, k - len + j)) ok = 1'b0;
                    end
                    if (ok) f[k*FAIL_W +: FAIL_W] = FAIL_W'(len);
                end
            end
        end
        return f;
    endfunction

    function automatic logic check_params(input int w, input int depth, input int count_w,
                                          input int pbits);
        return (w >= 1) && (w <= MAX_W) && (depth >= 2) && (depth <= MAX_DEPTH) &&
               (count_w >= 1) && (count_w <= 32) && (pbits == w * depth);
    endfunction

endpackage

// File: rtl/seq_detector_n_if.sv
// Symbol stream in, match state/hit/count out; master drives symbols, slave is the detector.
// No backpressure: every qualified symbol is consumed on the edge it is presented.
interface seq_detector_n_if #(
    parameter int W       = 2,
    parameter int SW      = 2,
    parameter int COUNT_W = 8
);
    logic [W-1:0]       sym;
    logic               sym_valid;
    logic               overlap;
    logic               clr;
    logic [SW-1:0]      state;
    logic               hit;
    logic               hit_pulse;
    logic [COUNT_W-1:0] match_cnt;

    modport master (
        output sym, sym_valid, overlap, clr,
        input  state, hit, hit_pulse, match_cnt
    );

    modport slave (
        input  sym, sym_valid, overlap, clr,
        output state, hit, hit_pulse, match_cnt
    );
endinterface

// File: rtl/seq_det_next.sv
// Combinational KMP next-state: restart from full match, then follow the failure chain.
// Zero latency, no backpressure; the fail chain is unrolled DEPTH+1 times.
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int W       = 2,
    parameter int DEPTH   = 3,
    parameter     PATTERN = 6'b11_10_00,
    parameter int SW      = 2
) (
    input  logic [SW-1:0] k,
    input  logic [W-1:0]  s,
    input  logic          overlap,
    output logic [SW-1:0] next_k,
    output logic          enter_full
);
    localparam int            NK   = 1 << SW;
    localparam pat_vec_t      PV   = pat_vec_t'(PATTERN);
    localparam fail_vec_t     FAIL = prefix_fail(PV, W, DEPTH);
    localparam logic [SW-1:0] FULL = SW'(DEPTH);

    logic [W-1:0]  pat_sym [NK];
    logic [SW-1:0] fail_k  [NK];
    logic [SW-1:0] kk;
    logic          done;

    // Tables padded to 2**SW entries so every state encoding indexes in range.
    for (genvar i = 0; i < NK; i++) begin : g_tab
        if (i < DEPTH) begin : g_sym
            assign pat_sym[i] = W'(sym_at(PV, W, i));
        end else begin : g_sym_pad
            assign pat_sym[i] = '0;
        end
        if (i <= DEPTH) begin : g_fail
            assign fail_k[i] = SW'(FAIL[i*FAIL_W +: FAIL_W]);
        end else begin : g_fail_pad
            assign fail_k[i] = '0;
        end
    end

    always_comb begin
        kk     = (k == FULL) ? (overlap ? fail_k[FULL] : '0) : k;
        next_k = '0;
        done   = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (!done) begin
                if (kk != FULL && s == pat_sym[kk]) begin
                    next_k = kk + 1'b1;
                    done   = 1'b1;
                end else if (kk == '0) begin
                    done = 1'b1;
                end else begin
                    kk = fail_k[kk];
                end
            end
        end
        enter_full = (next_k == FULL);
    end

endmodule

// File: rtl/seq_detector_n.sv
// Parametrised pattern detector: registered prefix state, hit/hit_pulse flags, saturating match count.
// One-cycle latency from the completing symbol to hit; accepts a symbol every cycle, never stalls.
module seq_detector_n
    import seq_det_pkg::*;
#(
    parameter int W       = 2,
    parameter int DEPTH   = 3,
    parameter     PATTERN = 6'b11_10_00,
    parameter int COUNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    seq_detector_n_if.slave  bus
);
    localparam int SW = clog2(DEPTH + 1);

    if (!check_params(W, DEPTH, COUNT_W, $bits(PATTERN))) begin : g_bad_params
        $error("seq_detector_n: W, DEPTH, COUNT_W or PATTERN width out of range");
    end

    logic [SW-1:0]      state_q;
    logic [SW-1:0]      next_k;
    logic               enter_full;
    logic               hit_q;
    logic               pulse_q;
    logic [COUNT_W-1:0] cnt_q;

    seq_det_next #(
        .W       (W),
        .DEPTH   (DEPTH),
        .PATTERN (PATTERN),
        .SW      (SW)
    ) u_next (
        .k          (state_q),
        .s          (bus.sym),
        .overlap    (bus.overlap),
        .next_k     (next_k),
        .enter_full (enter_full)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_q <= '0;
            hit_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.sym_valid) begin
            state_q <= next_k;
            hit_q   <= enter_full;
            pulse_q <= enter_full;
            if (enter_full && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign bus.state     = state_q;
    assign bus.hit       = hit_q;
    assign bus.hit_pulse = pulse_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Drives three detector configurations from one stimulus stream and checks them against a
// suffix-matching reference model (history of symbols since the last restart).
module tb_seq_detector_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detector_n_if #(.W(2), .SW(2), .COUNT_W(8)) ifa ();
    seq_detector_n_if #(.W(1), .SW(3), .COUNT_W(8)) ifb ();
    seq_detector_n_if #(.W(1), .SW(2), .COUNT_W(2)) ifc ();

    seq_detector_n #(.W(2), .DEPTH(3), .PATTERN(6'b11_10_00), .COUNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_detector_n #(.W(1), .DEPTH(4), .PATTERN(4'b1101), .COUNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_detector_n #(.W(1), .DEPTH(3), .PATTERN(3'b111), .COUNT_W(2))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct packed {
        int   hist;
        int   hlen;
        int   st;
        int   cnt;
        logic pulse;
    } mdl_t;

    mdl_t ma, mb, mc;
    int   total = 0;
    int   bad   = 0;
    int   pulses_c;

    // Longest L such that the last L symbols of history spell P[0..L-1]; newest symbol in low bits.
    function automatic int best_len(input int hist, input int hlen, input int pat,
                                    input int w, input int depth);
        int   mask;
        int   lim;
        logic ok;
        mask = (1 << w) - 1;
        lim  = (hlen < depth) ? hlen : depth;
        for (int len = lim; len >= 1; len--) begin
            ok = 1'b1;
            for (int j = 0; j < len; j++) begin
                if (((hist >> ((len - 1 - j) * w)) & mask) != ((pat >> (j * w)) & mask)) ok = 1'b0;
            end
            if (ok) return len;
        end
        return 0;
    endfunction

    function automatic mdl_t upd(input mdl_t m, input logic r, input logic c, input logic v,
                                 input int s, input logic ov, input int pat, input int w,
                                 input int depth, input int cmax);
        mdl_t n;
        n       = m;
        n.pulse = 1'b0;
        if (r || c) begin
            n = '0;
        end else if (v) begin
            if (m.st == depth && !ov) begin
                n.hist = 0;
                n.hlen = 0;
            end
            n.hist  = ((n.hist << w) | s) & ((1 << (w * depth)) - 1);
            n.hlen  = (n.hlen < depth) ? n.hlen + 1 : depth;
            n.st    = best_len(n.hist, n.hlen, pat, w, depth);
            n.pulse = (n.st == depth);
            if (n.pulse && n.cnt < cmax) n.cnt = n.cnt + 1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_state", 32'(ifa.state),     ma.st);
        chk("a_hit",   32'(ifa.hit),       (ma.st == 3) ? 1 : 0);
        chk("a_pulse", 32'(ifa.hit_pulse), 32'(ma.pulse));
        chk("a_cnt",   32'(ifa.match_cnt), ma.cnt);
        chk("b_state", 32'(ifb.state),     mb.st);
        chk("b_hit",   32'(ifb.hit),       (mb.st == 4) ? 1 : 0);
        chk("b_pulse", 32'(ifb.hit_pulse), 32'(mb.pulse));
        chk("b_cnt",   32'(ifb.match_cnt), mb.cnt);
        chk("c_state", 32'(ifc.state),     mc.st);
        chk("c_hit",   32'(ifc.hit),       (mc.st == 3) ? 1 : 0);
        chk("c_pulse", 32'(ifc.hit_pulse), 32'(mc.pulse));
        chk("c_cnt",   32'(ifc.match_cnt), mc.cnt);
    endtask

    task automatic step(input logic r, input logic c, input logic v, input int sa, input int sb,
                        input int sc, input logic ov);
        rst           = r;
        ifa.clr       = c;  ifb.clr       = c;  ifc.clr       = c;
        ifa.sym_valid = v;  ifb.sym_valid = v;  ifc.sym_valid = v;
        ifa.overlap   = ov; ifb.overlap   = ov; ifc.overlap   = ov;
        ifa.sym       = 2'(sa);
        ifb.sym       = 1'(sb);
        ifc.sym       = 1'(sc);
        @(posedge clk);
        ma = upd(ma, r, c, v, sa, ov, 'b11_10_00, 2, 3, 255);
        mb = upd(mb, r, c, v, sb, ov, 'b1101,     1, 4, 255);
        mc = upd(mc, r, c, v, sc, ov, 'b111,      1, 3, 3);
        #1;
        check_all();
        if (ifc.hit_pulse === 1'b1) pulses_c++;
    endtask

    int sa_tab[6] = '{0, 2, 3, 1, 0, 2};
    int sb_tab[6] = '{1, 0, 1, 0, 1, 1};
    int b_st[6]   = '{1, 2, 3, 2, 3, 4};

    initial begin
        ma = '0; mb = '0; mc = '0;
        pulses_c = 0;

        // Reset values.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_a_state", 32'(ifa.state), 0);
        chk("rst_c_cnt",   32'(ifc.match_cnt), 0);

        // Non-overlap: A sees 00,10,11; B sees 1,0,1,0,1,1; C sees six 1s.
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, sa_tab[i], sb_tab[i], 1, 0);
            chk("b_state_seq", 32'(ifb.state), b_st[i]);
            if (i == 2) begin
                chk("a_hit_after_3",   32'(ifa.hit), 1);
                chk("a_pulse_after_3", 32'(ifa.hit_pulse), 1);
                chk("a_cnt_after_3",   32'(ifa.match_cnt), 1);
            end
        end
        chk("b_cnt_single", 32'(ifb.match_cnt), 1);
        chk("c_cnt_nonovl", 32'(ifc.match_cnt), 2);

        // Overlap: five 1s on C give three pulses, then five more keep the counter saturated.
        step(1, 0, 0, 0, 0, 0, 1);
        pulses_c = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 1, 1);
        chk("c_pulses_ovl", 32'(pulses_c), 3);
        chk("c_cnt_ovl",    32'(ifc.match_cnt), 3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 1, 1);
        chk("c_pulses_sat", 32'(pulses_c), 8);
        chk("c_cnt_sat",    32'(ifc.match_cnt), 3);

        // Gap mid-pattern, then idle after the match: state and hit hold.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 3, 0, 1, 1);
        chk("a_state_gap", 32'(ifa.state), 1);
        step(0, 0, 1, 2, 1, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 0);
        chk("a_hit_idle", 32'(ifa.hit), 1);

        // Reset together with a symbol at state 2.
        step(0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 1, 2, 1, 1, 0);
        step(1, 0, 1, 3, 1, 1, 0);
        chk("a_state_rst_sym", 32'(ifa.state), 0);
        chk("a_cnt_rst_sym",   32'(ifa.match_cnt), 0);

        // Clear together with the completing symbol.
        step(0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 1, 2, 1, 1, 0);
        step(0, 1, 1, 3, 1, 1, 0);
        chk("a_pulse_clr", 32'(ifa.hit_pulse), 0);
        chk("a_state_clr", 32'(ifa.state), 0);

        // Random traffic with occasional clears/resets and overlap toggling.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
